// File: rtl/controller_frame_writer_pkg.sv
// Shared definitions for the controller frame writer: FSM encoding and header layout.
// The header word packs the published sequence number above the payload length.
package controller_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_DROP = 3'd2,
    ST_HDR  = 3'd3,
    ST_PUB  = 3'd4
  } state_t;

  localparam int SEQ_MSB = 31;
  localparam int SEQ_LSB = 16;
  localparam int LEN_MSB = 15;
  localparam int LEN_LSB = 0;

  function automatic logic [31:0] make_header(input logic [15:0] seq, input logic [15:0] len);
    logic [31:0] hdr;
    hdr = '0;
    hdr[SEQ_MSB:SEQ_LSB] = seq;
    hdr[LEN_MSB:LEN_LSB] = len;
    return hdr;
  endfunction

endpackage

// File: rtl/controller_frame_writer.sv
// Stream-to-RAM writer: fills one bank of a ping-pong pair with a frame, then writes
// a {seq,len} header at the bank base, publishes the bank and pulses frame_irq.
//
// state | meaning
// IDLE  | waiting for a sop word; non-sop words are dropped as framing errors
// DATA  | storing payload words of the current frame
// DROP  | frame overflowed the bank; discarding until eop
// HDR   | writing the header word to the write-bank base
// PUB   | flipping rd_bank, advancing frame_seq, pulsing frame_irq
module controller_frame_writer
  import controller_frame_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 32,
  parameter int                BANK_WORDS = 128,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [3:0]        ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  output logic              rd_bank,
  output logic [15:0]       frame_seq,
  output logic              frame_irq,
  output logic              err_overflow,
  output logic              err_framing,
  input  logic              err_clear
);

  localparam int LEN_W = $clog2(BANK_WORDS) + 1;
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(BANK_WORDS - 1);

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] wbase;
  logic              accept;
  logic              framing_set;
  logic              overflow_set;

  // The write bank is always the one not currently published.
  assign wbase = rd_bank ? BASE_ADDR : BASE_ADDR + ADDR_W'(BANK_WORDS);

  assign in_ready       = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_DROP);
  assign accept         = in_valid && in_ready;
  assign ram_chipselect = ram_write;
  assign ram_byteenable = {4{ram_write}};
  assign ram_clken      = 1'b1;

  always_comb begin
    framing_set  = 1'b0;
    overflow_set = 1'b0;
    if (accept) begin
      if (state == ST_IDLE && !in_sop) framing_set = 1'b1;
      if (state == ST_DATA && in_sop)  framing_set = 1'b1;
      if (state == ST_DATA && !in_sop && len == LEN_FULL) overflow_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      len           <= '0;
      rd_bank       <= 1'b0;
      frame_seq     <= '0;
      frame_irq     <= 1'b0;
      err_overflow  <= 1'b0;
      err_framing   <= 1'b0;
      ram_write     <= 1'b0;
      ram_address   <= '0;
      ram_writedata <= '0;
    end else begin
      ram_write    <= 1'b0;
      frame_irq    <= 1'b0;
      err_framing  <= framing_set  | (err_framing  & ~err_clear);
      err_overflow <= overflow_set | (err_overflow & ~err_clear);

      case (state)
        ST_IDLE: begin
          if (accept && in_sop) begin
            ram_write     <= 1'b1;
            ram_address   <= wbase + ADDR_W'(1);
            ram_writedata <= in_data;
            len           <= LEN_W'(1);
            state         <= in_eop ? ST_HDR : ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            if (in_sop) begin
              // Restart the frame in place; the partial payload is simply overwritten.
              ram_write     <= 1'b1;
              ram_address   <= wbase + ADDR_W'(1);
              ram_writedata <= in_data;
              len           <= LEN_W'(1);
              state         <= in_eop ? ST_HDR : ST_DATA;
            end else if (len == LEN_FULL) begin
              state <= in_eop ? ST_IDLE : ST_DROP;
            end else begin
              ram_write     <= 1'b1;
              ram_address   <= wbase + ADDR_W'(1) + ADDR_W'(len);
              ram_writedata <= in_data;
              len           <= len + LEN_W'(1);
              if (in_eop) state <= ST_HDR;
            end
          end
        end
        ST_DROP: begin
          if (accept && in_eop) state <= ST_IDLE;
        end
        ST_HDR: begin
          ram_write     <= 1'b1;
          ram_address   <= wbase;
          ram_writedata <= DATA_W'(make_header(frame_seq + 16'd1, 16'(len)));
          state         <= ST_PUB;
        end
        ST_PUB: begin
          rd_bank   <= ~rd_bank;
          frame_seq <= frame_seq + 16'd1;
          frame_irq <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_frame_writer.sv
// Scoreboard bench for controller_frame_writer: expected RAM writes and publish events
// are queued by the stimulus and popped by a negedge monitor as the DUT produces them.
module tb_controller_frame_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic [7:0]  ram_address;
  logic        ram_chipselect;
  logic        ram_write;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic        ram_clken;
  logic        rd_bank;
  logic [15:0] frame_seq;
  logic        frame_irq;
  logic        err_overflow;
  logic        err_framing;
  logic        err_clear = 1'b0;

  always #5 clk = ~clk;

  controller_frame_writer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_byteenable (ram_byteenable),
    .ram_writedata  (ram_writedata),
    .ram_clken      (ram_clken),
    .rd_bank        (rd_bank),
    .frame_seq      (frame_seq),
    .frame_irq      (frame_irq),
    .err_overflow   (err_overflow),
    .err_framing    (err_framing),
    .err_clear      (err_clear)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem [256];
  wr_t         exp_wr[$];
  logic [16:0] exp_pub[$];
  wr_t         mon_wr;
  logic [16:0] mon_pub;

  // RAM port-2 model
  always @(posedge clk)
    if (ram_chipselect && ram_write) mem[ram_address] <= ram_writedata;

  always @(negedge clk) begin
    if (ram_write || ram_chipselect) begin
      n_vec++;
      if (exp_wr.size() == 0) begin
        n_err++;
        $display("FAIL ram_wr_unexpected: got addr=%h data=%h, required no write", ram_address, ram_writedata);
      end else begin
        mon_wr = exp_wr.pop_front();
        if (ram_address !== mon_wr.addr || ram_writedata !== mon_wr.data ||
            ram_chipselect !== 1'b1 || ram_write !== 1'b1 || ram_byteenable !== 4'hF) begin
          n_err++;
          $display("FAIL ram_wr: got addr=%h data=%h cs=%b be=%h, required addr=%h data=%h cs=1 be=f",
                   ram_address, ram_writedata, ram_chipselect, ram_byteenable, mon_wr.addr, mon_wr.data);
        end
      end
    end
    if (frame_irq) begin
      n_vec++;
      if (exp_pub.size() == 0) begin
        n_err++;
        $display("FAIL irq_unexpected: got irq with bank=%b seq=%h, required none", rd_bank, frame_seq);
      end else begin
        mon_pub = exp_pub.pop_front();
        if ({rd_bank, frame_seq} !== mon_pub) begin
          n_err++;
          $display("FAIL publish: got bank=%b seq=%h, required bank=%b seq=%h",
                   rd_bank, frame_seq, mon_pub[16], mon_pub[15:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_wr(input logic [7:0] addr, input logic [31:0] data);
    exp_wr.push_back({addr, data});
  endtask

  task automatic push_pub(input logic bank, input logic [15:0] seq);
    exp_pub.push_back({bank, seq});
  endtask

  // Presents one word and returns after the edge that accepts it; waited = cycles stalled.
  task automatic send(input logic [31:0] d, input logic s, input logic e, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required acceptance", waited);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_write", 32'(ram_write), 32'd0);
    check("rst_ram_cs", 32'(ram_chipselect), 32'd0);
    check("rst_ram_be", 32'(ram_byteenable), 32'd0);
    check("rst_ram_clken", 32'(ram_clken), 32'd1);
    check("rst_rd_bank", 32'(rd_bank), 32'd0);
    check("rst_frame_seq", 32'(frame_seq), 32'd0);
    check("rst_irq", 32'(frame_irq), 32'd0);
    check("rst_errs", {30'd0, err_overflow, err_framing}, 32'd0);
    reset_n = 1'b1;
    idle(1);

    // 3-word frame into bank 1
    push_wr(8'd129, 32'hA000_0001);
    push_wr(8'd130, 32'hA000_0002);
    push_wr(8'd131, 32'hA000_0003);
    push_wr(8'd128, 32'h0001_0003);
    push_pub(1'b1, 16'd1);
    send(32'hA000_0001, 1'b1, 1'b0, w);
    send(32'hA000_0002, 1'b0, 1'b0, w);
    send(32'hA000_0003, 1'b0, 1'b1, w);
    @(negedge clk); check("irq_cycle1", 32'(frame_irq), 32'd0);
    @(negedge clk); check("irq_cycle2", 32'(frame_irq), 32'd0);
    @(negedge clk); check("irq_cycle3", 32'(frame_irq), 32'd1);
    @(negedge clk); check("irq_cycle4", 32'(frame_irq), 32'd0);
    check("t1_rd_bank", 32'(rd_bank), 32'd1);
    check("t1_seq", 32'(frame_seq), 32'd1);
    check("t1_mem128", mem[128], 32'h0001_0003);
    check("t1_mem131", mem[131], 32'hA000_0003);

    // 1-word frame into bank 0
    push_wr(8'd1, 32'hB000_0001);
    push_wr(8'd0, 32'h0002_0001);
    push_pub(1'b0, 16'd2);
    send(32'hB000_0001, 1'b1, 1'b1, w);
    idle(4);
    check("t2_mem1", mem[1], 32'hB000_0001);
    check("t2_mem0", mem[0], 32'h0002_0001);
    check("t2_rd_bank", 32'(rd_bank), 32'd0);
    check("t2_bank1_keep", mem[129], 32'hA000_0001);
    check("t2_bank1_hdr", mem[128], 32'h0001_0003);

    // 130-word frame overflows bank 1
    for (int i = 0; i < 130; i++) begin
      if (i < 127) push_wr(8'(129 + i), 32'hC000_0000 + 32'(i));
      send(32'hC000_0000 + 32'(i), i == 0, i == 129, w);
    end
    idle(4);
    check("t3_overflow", 32'(err_overflow), 32'd1);
    check("t3_framing", 32'(err_framing), 32'd0);
    check("t3_rd_bank", 32'(rd_bank), 32'd0);
    check("t3_seq", 32'(frame_seq), 32'd2);
    check("t3_mem255", mem[255], 32'hC000_007E);
    check("t3_pending", 32'(exp_wr.size()), 32'd0);
    push_wr(8'd129, 32'hD000_0001);
    push_wr(8'd130, 32'hD000_0002);
    push_wr(8'd128, 32'h0003_0002);
    push_pub(1'b1, 16'd3);
    send(32'hD000_0001, 1'b1, 1'b0, w);
    send(32'hD000_0002, 1'b0, 1'b1, w);
    idle(4);
    check("t3_good_bank", 32'(rd_bank), 32'd1);
    check("t3_good_seq", 32'(frame_seq), 32'd3);

    // framing errors: stray word in IDLE, then sop restart mid-frame in bank 0
    send(32'hBAD0_0000, 1'b0, 1'b0, w);
    idle(2);
    check("t4_framing_idle", 32'(err_framing), 32'd1);
    push_wr(8'd1, 32'hE000_0001);
    push_wr(8'd2, 32'hE000_0002);
    push_wr(8'd1, 32'hE000_0003);
    push_wr(8'd2, 32'hE000_0004);
    push_wr(8'd0, 32'h0004_0002);
    push_pub(1'b0, 16'd4);
    send(32'hE000_0001, 1'b1, 1'b0, w);
    send(32'hE000_0002, 1'b0, 1'b0, w);
    send(32'hE000_0003, 1'b1, 1'b0, w);
    send(32'hE000_0004, 1'b0, 1'b1, w);
    idle(4);
    check("t4_hdr", mem[0], 32'h0004_0002);
    check("t4_mem1", mem[1], 32'hE000_0003);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    check("t4_clear", {30'd0, err_overflow, err_framing}, 32'd0);

    // sequence wrap FFFF -> 0000, frame into bank 1
    force dut.frame_seq = 16'hFFFF;
    #1;
    release dut.frame_seq;
    idle(1);
    check("t5_preload", 32'(frame_seq), 32'h0000_FFFF);
    push_wr(8'd129, 32'hF000_0001);
    push_wr(8'd128, 32'h0000_0001);
    push_pub(1'b1, 16'd0);
    send(32'hF000_0001, 1'b1, 1'b1, w);
    idle(4);
    check("t5_seq_wrap", 32'(frame_seq), 32'd0);
    check("t5_hdr", mem[128], 32'h0000_0001);

    // reset mid-frame after 5 words in bank 0
    for (int i = 0; i < 5; i++) begin
      push_wr(8'(1 + i), 32'h1100_0000 + 32'(i));
      send(32'h1100_0000 + 32'(i), i == 0, 1'b0, w);
    end
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(3);
    check("t6_rd_bank", 32'(rd_bank), 32'd0);
    check("t6_seq", 32'(frame_seq), 32'd0);
    check("t6_pending", 32'(exp_wr.size()), 32'd0);
    check("t6_hdr_untouched", mem[0], 32'h0004_0002);

    // in_ready low exactly for HDR and PUB while the next sop is held valid
    push_wr(8'd129, 32'h2200_0001);
    push_wr(8'd128, 32'h0001_0001);
    push_pub(1'b1, 16'd1);
    push_wr(8'd1, 32'h3300_0001);
    push_wr(8'd2, 32'h3300_0002);
    push_wr(8'd0, 32'h0002_0002);
    push_pub(1'b0, 16'd2);
    send(32'h2200_0001, 1'b1, 1'b1, w);
    check("t6_wait_first", 32'(w), 32'd0);
    send(32'h3300_0001, 1'b1, 1'b0, w);
    check("t6_wait_hdr_pub", 32'(w), 32'd2);
    send(32'h3300_0002, 1'b0, 1'b1, w);
    check("t6_wait_data", 32'(w), 32'd0);
    idle(6);
    check("end_wr_queue", 32'(exp_wr.size()), 32'd0);
    check("end_pub_queue", 32'(exp_pub.size()), 32'd0);
    check("end_seq", 32'(frame_seq), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
